// File: rtl/wma_inverse_filter_if.sv
// rtl/wma_inverse_filter_if.sv - sample stream bundle between the FIR link and the inverse filter
interface wma_inverse_filter_if #(
    parameter int N = 8
);
    logic [N-1:0] data_in;
    logic         in_valid;
    logic [N-1:0] data_out;
    logic         out_valid;

    // Source of filtered samples and sink of recovered samples
    modport master (
        output data_in,
        output in_valid,
        input  data_out,
        input  out_valid
    );

    // The inverse filter itself
    modport slave (
        input  data_in,
        input  in_valid,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/wma_inverse_filter.sv
// rtl/wma_inverse_filter.sv - recursive inverse of the 1, 1/2, 1/4, 1/8 weighted moving-average FIR
module wma_inverse_filter #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    wma_inverse_filter_if.slave bus,
    input  logic             sync_clr,
    output logic             primed,
    output logic [CNT_W-1:0] sample_cnt
);
    // History of previously decoded samples x[n-1], x[n-2], x[n-3]
    logic [N-1:0]     h1;
    logic [N-1:0]     h2;
    logic [N-1:0]     h3;
    logic [1:0]       pc;
    logic [N-1:0]     x;
    logic [N-1:0]     data_out_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] cnt_r;

    // Undo the FIR sum: subtracting the same truncated terms mod 2^N is bit-exact,
    // and must stay a single-cycle path so back-to-back samples see fresh history
    always_comb begin
        x = bus.data_in - (h1 >> 1) - (h2 >> 2) - (h3 >> 3);
    end

    // Decode, history shift, priming and sample counting
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            h1          <= '0;
            h2          <= '0;
            h3          <= '0;
            pc          <= 2'd0;
            cnt_r       <= '0;
        end else if (sync_clr) begin
            // Resync: history restarts from zero to match a freshly cleared FIR;
            // the last output value and the running count are kept
            h1          <= '0;
            h2          <= '0;
            h3          <= '0;
            pc          <= 2'd0;
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            data_out_r  <= x;
            out_valid_r <= 1'b1;
            h1          <= x;
            h2          <= h1;
            h3          <= h2;
            if (pc != 2'd3) begin
                pc <= pc + 2'd1;
            end
            cnt_r       <= cnt_r + 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.out_valid = out_valid_r;
    assign sample_cnt    = cnt_r;
    assign primed        = (pc == 2'd3);
endmodule

// File: tb/tb_wma_inverse_filter.sv
// tb/tb_wma_inverse_filter.sv - scoreboard bench for the WMA inverse filter
module tb_wma_inverse_filter;
    localparam int N     = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             sync_clr;
    logic             primed;
    logic [CNT_W-1:0] sample_cnt;

    wma_inverse_filter_if #(.N(N)) bus ();

    wma_inverse_filter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sync_clr   (sync_clr),
        .primed     (primed),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]     d;
        logic             p;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           exp_cnt = 0;
    int           exp_pc = 0;
    logic [N-1:0] last_exp = '0;
    logic [N-1:0] f1 = '0;
    logic [N-1:0] f2 = '0;
    logic [N-1:0] f3 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] d);
        exp_t e;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        if (exp_pc < 3) exp_pc++;
        e.d = d;
        e.p = (exp_pc == 3);
        e.c = CNT_W'(exp_cnt);
        sb.push_back(e);
        last_exp = d;
    endtask

    // Forward FIR reference: y = x + (x1>>1) + (x2>>2) + (x3>>3) mod 2^N
    task automatic fir_encode(input logic [N-1:0] xv, output logic [N-1:0] yv);
        yv = xv + (f1 >> 1) + (f2 >> 2) + (f3 >> 3);
        f3 = f2;
        f2 = f1;
        f1 = xv;
    endtask

    task automatic send(input logic [N-1:0] din, input logic [N-1:0] dexp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.data_in  = din;
        push_exp(dexp);
    endtask

    // Gap cycles; from the second one on the output must be idle and holding
    task automatic idle(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.data_in  = 8'hA5;
            @(negedge clk);
            if (k >= 2) begin
                check("gap_out_valid", 32'(bus.out_valid), 32'd0);
                check("gap_hold", 32'(bus.data_out), 32'(last_exp));
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = 8'h55;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt  = 0;
        exp_pc   = 0;
        last_exp = '0;
        f1 = '0;
        f2 = '0;
        f3 = '0;
        @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_primed", 32'(primed), 32'd0);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
    endtask

    task automatic do_sync_clr();
        @(posedge clk);
        #1;
        sync_clr     = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = 8'h33;
        @(posedge clk);
        #1;
        sync_clr     = 1'b0;
        bus.in_valid = 1'b0;
        exp_pc = 0;
        @(negedge clk);
        check("clr_out_valid", 32'(bus.out_valid), 32'd0);
        check("clr_hold", 32'(bus.data_out), 32'(last_exp));
        check("clr_primed", 32'(primed), 32'd0);
        check("clr_cnt", 32'(sample_cnt), 32'(exp_cnt));
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.d));
                check("primed", 32'(primed), 32'(e.p));
                check("sample_cnt", 32'(sample_cnt), 32'(e.c));
            end
        end
    end

    initial begin
        logic [N-1:0] xv;
        logic [N-1:0] yv;
        int           waited;

        reset        = 1'b1;
        sync_clr     = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("init_data_out", 32'(bus.data_out), 32'd0);
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        check("init_primed", 32'(primed), 32'd0);
        check("init_cnt", 32'(sample_cnt), 32'd0);

        // Basic decode, back to back
        send(8'h80, 8'h80);
        send(8'h80, 8'h40);
        send(8'h60, 8'h20);
        send(8'h40, 8'h10);
        idle(2);

        // Resync then a fresh first sample
        do_sync_clr();
        send(8'h80, 8'h80);
        idle(2);

        // Reset with a sample present; the sample must not reach history
        do_reset();
        send(8'hFF, 8'hFF);
        send(8'h7E, 8'hFF);
        idle(2);

        // Truncating shifts
        do_reset();
        send(8'h03, 8'h03);
        send(8'h04, 8'h03);
        send(8'h04, 8'h03);
        idle(2);

        // Basic decode with two-cycle gaps
        do_reset();
        send(8'h80, 8'h80);
        idle(2);
        send(8'h80, 8'h40);
        idle(2);
        send(8'h60, 8'h20);
        idle(2);
        send(8'h40, 8'h10);
        idle(2);

        // Loopback through the forward FIR with random gaps
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            xv = N'($urandom);
            fir_encode(xv, yv);
            send(yv, xv);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
